lettura_pattern: RTL and testbench
==================================

Name: lettura_pattern

Overview:
- Downstream read-side consumer of the write/read sequencing FSM in the mining datapath.
- While the FSM is in the read phase (state 2'b10), it scans the 512-entry BRAM at the FSM-driven read address.
- Each word is compared against a masked pattern and matches are counted.
- It requests each address advance and signals end of read (fine_lettura) back to the FSM.

Parameters:
- DATA_W, 32, BRAM word width.
- ADDR_W, 9, read address width.
- DEPTH, 512, number of entries scanned (must be ≤ 2**ADDR_W).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- state  in  2  FSM phase: 00 idle, 01 write, 10 read, 11 done.
- indirizzo_read  in  ADDR_W  current BRAM read address driven by the FSM.
- dato_ram  in  DATA_W  BRAM dout, registered, 1-cycle latency from address.
- pattern  in  DATA_W  value to match; quasi-static during a scan.
- maschera  in  DATA_W  bit mask; 1 = bit compared.
- avanza  out  1  1-cycle pulse; the top level ORs it into the FSM's fine_scrittura to advance indirizzo_read.
- fine_lettura  out  1  1-cycle pulse after the last entry is compared.
- conteggio  out  ADDR_W+1  number of matching entries.
- valido  out  1  conteggio final and valid.
- occupato  out  1  scan in progress.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; internal state IDLE; entry detector cleared.
- Internal states: IDLE, ATT_IND, ATT_DATO, CONFRONTA, FINE.
- IDLE:
  - Wait for the rising edge of the read phase: state==10 while the previous sampled state!=10.
  - On that edge: clear conteggio and valido, set occupato=1, go to ATT_IND.
- ATT_IND (1 cycle): lets indirizzo_read settle after an FSM update. Go to ATT_DATO.
- ATT_DATO (1 cycle): covers the BRAM read latency. Go to CONFRONTA.
- CONFRONTA (1 cycle):
  - Match = ((dato_ram ^ pattern) & maschera) == 0. On match, conteggio += 1.
  - If indirizzo_read == DEPTH-1: pulse fine_lettura, set valido=1, clear occupato, go to FINE.
  - Otherwise: pulse avanza and go to ATT_IND.
- Timing: exactly 3 cycles per entry. fine_lettura is asserted in the 3·DEPTH-th cycle after the entry edge (cycle 1536 for DEPTH=512). Exactly DEPTH-1 avanza pulses per scan.
- FINE:
  - Hold conteggio and valido while state is 11 or 10.
  - On state==00 or 01: go to IDLE, keeping conteggio and valido until the next entry edge.
- Abort: if state leaves 10 while in ATT_IND, ATT_DATO or CONFRONTA (FSM fine/reset):
  - Go to IDLE with no fine_lettura and no avanza that cycle.
  - valido=0, occupato=0; conteggio holds its partial value, which is not meaningful.
- Arithmetic: conteggio is ADDR_W+1 bits. Maximum is DEPTH (512), so no overflow and no saturation logic.
- Re-entry: a new 10-entry edge after any path restarts the scan with a cleared count.
- Simultaneous events: asynchronous reset dominates everything. Abort dominates a CONFRONTA completion in the same cycle.

Optional Feature:
- Macro: LETTURA_PRIMO_INDICE_EN.
- Defined:
  - Adds outputs trovato (1 bit) and indice_primo (ADDR_W bits).
  - On the first match of a scan, they latch 1 and indirizzo_read; both clear at the entry edge and on reset.
  - After a scan with no match, trovato=0 and indice_primo=0.
- Not defined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package (mining_pkg):
  - FSM phase encodings ST_IDLE=00, ST_SCRITTURA=01, ST_LETTURA=10, ST_FINITO=11.
  - DEPTH and ADDR_W defaults.
  - Internal scan-state enum.
- Sub-module comparatore_mascherato: purely combinational; inputs dato, pattern, maschera; output match. It is reused by later mining stages.

Test Plan:
- All 512 words 0xDEADBEEF, pattern 0xDEADBEEF, maschera 0xFFFFFFFF → conteggio=512, valido=1, fine_lettura once at cycle 1536 after entry, 511 avanza pulses.
- Word i = i, pattern 0x42, maschera 0x000000FF → conteggio=2 (entries 0x042 and 0x142); with macro, trovato=1 and indice_primo=0x042.
- All words 0, pattern 0x1, maschera 0xFFFFFFFF → conteggio=0, fine_lettura still pulses once, valido=1; with macro, trovato=0.
- state forced 10→00 at address 100 → no fine_lettura, valido=0, occupato=0, IDLE. A following 01→10 sequence rescans from count 0 to the correct result.
- reset driven low between clock edges mid-scan → all outputs 0 immediately without a clock edge; after release, no activity until the next 10-entry edge.
- Two back-to-back scans with maschera=0 → conteggio=512 each time; second scan starts from 0 and valido drops at the second entry edge.

Source files
------------

// File: rtl/mining_pkg.sv
// Shared definitions for the mining datapath: FSM phase encodings, default
// BRAM geometry and the read-side scan state enum.
package mining_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;
  localparam int DEPTH_DEF  = 512;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_SCRITTURA = 2'b01,
    ST_LETTURA   = 2'b10,
    ST_FINITO    = 2'b11
  } fase_t;

  typedef enum logic [2:0] {
    SC_IDLE,
    SC_ATT_IND,
    SC_ATT_DATO,
    SC_CONFRONTA,
    SC_FINE
  } scan_t;

endpackage

// File: rtl/comparatore_mascherato.sv
// Masked equality comparator: bits with maschera=1 must match the pattern.
module comparatore_mascherato
  import mining_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] dato,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] maschera,
  output logic              match
);

  assign match = (((dato ^ pattern) & maschera) == '0);

endmodule

// File: rtl/lettura_pattern.sv
// Read-phase BRAM scanner: counts masked pattern matches, paces the FSM address.
// Optional first-match capture (trovato/indice_primo) under LETTURA_PRIMO_INDICE_EN.
module lettura_pattern
  import mining_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        state,
  input  logic [ADDR_W-1:0] indirizzo_read,
  input  logic [DATA_W-1:0] dato_ram,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] maschera,
  output logic              avanza,
  output logic              fine_lettura,
  output logic [ADDR_W:0]   conteggio,
  output logic              valido,
  output logic              occupato
`ifdef LETTURA_PRIMO_INDICE_EN
  ,
  output logic              trovato,
  output logic [ADDR_W-1:0] indice_primo
`endif
);

  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   UNO    = (ADDR_W + 1)'(1);

  scan_t             scan_q, scan_d;
  logic [1:0]        state_prev_q;
  logic [ADDR_W:0]   conteggio_q, conteggio_d;
  logic              valido_q, valido_d;
  logic              occupato_q, occupato_d;
  logic              match;
  logic              in_lettura;
  logic              ingresso;
  logic              in_scansione;

`ifdef LETTURA_PRIMO_INDICE_EN
  logic              trovato_q, trovato_d;
  logic [ADDR_W-1:0] indice_primo_q, indice_primo_d;
`endif

  comparatore_mascherato #(.DATA_W(DATA_W)) u_cmp (
    .dato     (dato_ram),
    .pattern  (pattern),
    .maschera (maschera),
    .match    (match)
  );

  assign in_lettura   = (state == ST_LETTURA);
  assign ingresso     = in_lettura && (state_prev_q != ST_LETTURA);
  assign in_scansione = (scan_q inside {SC_ATT_IND, SC_ATT_DATO, SC_CONFRONTA});

  always_comb begin
    scan_d       = scan_q;
    conteggio_d  = conteggio_q;
    valido_d     = valido_q;
    occupato_d   = occupato_q;
    avanza       = 1'b0;
    fine_lettura = 1'b0;
`ifdef LETTURA_PRIMO_INDICE_EN
    trovato_d      = trovato_q;
    indice_primo_d = indice_primo_q;
`endif

    unique case (scan_q)
      SC_IDLE: begin
        if (ingresso) begin
          conteggio_d = '0;
          valido_d    = 1'b0;
          occupato_d  = 1'b1;
          scan_d      = SC_ATT_IND;
`ifdef LETTURA_PRIMO_INDICE_EN
          trovato_d      = 1'b0;
          indice_primo_d = '0;
`endif
        end
      end
      SC_ATT_IND:  scan_d = SC_ATT_DATO;
      SC_ATT_DATO: scan_d = SC_CONFRONTA;
      SC_CONFRONTA: begin
        if (match) begin
          conteggio_d = conteggio_q + UNO;
`ifdef LETTURA_PRIMO_INDICE_EN
          if (!trovato_q) begin
            trovato_d      = 1'b1;
            indice_primo_d = indirizzo_read;
          end
`endif
        end
        if (indirizzo_read == ULTIMO) begin
          fine_lettura = 1'b1;
          valido_d     = 1'b1;
          occupato_d   = 1'b0;
          scan_d       = SC_FINE;
        end else begin
          avanza = 1'b1;
          scan_d = SC_ATT_IND;
        end
      end
      SC_FINE: begin
        // Result stays visible through read/done; only idle/write releases us.
        if (!state[1]) scan_d = SC_IDLE;
      end
      default: scan_d = SC_IDLE;
    endcase

    // Leaving the read phase mid-scan wins over any completion this cycle.
    if (in_scansione && !in_lettura) begin
      scan_d       = SC_IDLE;
      avanza       = 1'b0;
      fine_lettura = 1'b0;
      conteggio_d  = conteggio_q;
      valido_d     = 1'b0;
      occupato_d   = 1'b0;
`ifdef LETTURA_PRIMO_INDICE_EN
      trovato_d      = trovato_q;
      indice_primo_d = indice_primo_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q       <= SC_IDLE;
      state_prev_q <= ST_IDLE;
      conteggio_q  <= '0;
      valido_q     <= 1'b0;
      occupato_q   <= 1'b0;
`ifdef LETTURA_PRIMO_INDICE_EN
      trovato_q      <= 1'b0;
      indice_primo_q <= '0;
`endif
    end else begin
      scan_q       <= scan_d;
      state_prev_q <= state;
      conteggio_q  <= conteggio_d;
      valido_q     <= valido_d;
      occupato_q   <= occupato_d;
`ifdef LETTURA_PRIMO_INDICE_EN
      trovato_q      <= trovato_d;
      indice_primo_q <= indice_primo_d;
`endif
    end
  end

  assign conteggio = conteggio_q;
  assign valido    = valido_q;
  assign occupato  = occupato_q;
`ifdef LETTURA_PRIMO_INDICE_EN
  assign trovato      = trovato_q;
  assign indice_primo = indice_primo_q;
`endif

endmodule

// File: tb/tb_lettura_pattern.sv
// Directed bench for lettura_pattern with a BRAM and address-counter model.
// Also checks trovato/indice_primo when built with LETTURA_PRIMO_INDICE_EN.
module tb_lettura_pattern;
  import mining_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  state;
  logic [8:0]  addr;
  logic [31:0] dato_ram;
  logic [31:0] pattern;
  logic [31:0] maschera;
  logic        avanza;
  logic        fine_lettura;
  logic [9:0]  conteggio;
  logic        valido;
  logic        occupato;
`ifdef LETTURA_PRIMO_INDICE_EN
  logic        trovato;
  logic [8:0]  indice_primo;
`endif

  logic [31:0] mem [512];
  logic        addr_clr;
  logic        mon_clr;
  int          cyc = 0;
  int          av_n = 0;
  int          fine_n = 0;
  int          fine_at = 0;
  int          entry_cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  lettura_pattern dut (
    .clk            (clk),
    .reset          (reset),
    .state          (state),
    .indirizzo_read (addr),
    .dato_ram       (dato_ram),
    .pattern        (pattern),
    .maschera       (maschera),
    .avanza         (avanza),
    .fine_lettura   (fine_lettura),
    .conteggio      (conteggio),
    .valido         (valido),
    .occupato       (occupato)
`ifdef LETTURA_PRIMO_INDICE_EN
    ,
    .trovato        (trovato),
    .indice_primo   (indice_primo)
`endif
  );

  // FSM address counter and registered BRAM.
  always @(posedge clk) begin
    if (addr_clr) addr <= '0;
    else if (avanza && addr != 9'd511) addr <= addr + 9'd1;
    dato_ram <= mem[addr];
  end

  // Pulse monitor: counts avanza/fine_lettura and timestamps fine_lettura.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      av_n    <= 0;
      fine_n  <= 0;
      fine_at <= 0;
    end else begin
      if (avanza) av_n <= av_n + 1;
      if (fine_lettura) begin
        fine_n  <= fine_n + 1;
        fine_at <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pass through write phase (address cleared) then enter read phase.
  task automatic start_scan();
    @(negedge clk);
    state    = ST_SCRITTURA;
    addr_clr = 1'b1;
    mon_clr  = 1'b1;
    @(negedge clk);
    addr_clr  = 1'b0;
    mon_clr   = 1'b0;
    state     = ST_LETTURA;
    entry_cyc = cyc;
  endtask

  task automatic wait_fine(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fine_n != 0) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_no_timeout"}, 32'(ok), 32'd1);
  endtask

  initial begin
    reset    = 1'b0;
    state    = ST_IDLE;
    pattern  = '0;
    maschera = '0;
    addr_clr = 1'b1;
    mon_clr  = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_conteggio", 32'(conteggio), 32'd0);
    check("rst_valido", 32'(valido), 32'd0);
    check("rst_occupato", 32'(occupato), 32'd0);
    check("rst_avanza", 32'(avanza), 32'd0);
    check("rst_fine", 32'(fine_lettura), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // A: every word matches exactly
    for (int i = 0; i < 512; i++) mem[i] = 32'hDEADBEEF;
    pattern  = 32'hDEADBEEF;
    maschera = 32'hFFFFFFFF;
    start_scan();
    @(negedge clk);
    check("A_occupato_running", 32'(occupato), 32'd1);
    wait_fine("A");
    check("A_conteggio", 32'(conteggio), 32'd512);
    check("A_valido", 32'(valido), 32'd1);
    check("A_occupato", 32'(occupato), 32'd0);
    check("A_fine_count", 32'(fine_n), 32'd1);
    check("A_avanza_count", 32'(av_n), 32'd511);
    check("A_fine_cycle", 32'(fine_at - entry_cyc), 32'd1536);
`ifdef LETTURA_PRIMO_INDICE_EN
    check("A_trovato", 32'(trovato), 32'd1);
    check("A_indice", 32'(indice_primo), 32'd0);
`endif
    @(negedge clk);
    state = ST_FINITO;
    repeat (3) @(negedge clk);
    check("A_hold_valido", 32'(valido), 32'd1);
    check("A_hold_conteggio", 32'(conteggio), 32'd512);

    // B: word i = i, low byte must be 0x42 -> entries 0x042 and 0x142
    for (int i = 0; i < 512; i++) mem[i] = 32'(i);
    pattern  = 32'h42;
    maschera = 32'h000000FF;
    start_scan();
    wait_fine("B");
    check("B_conteggio", 32'(conteggio), 32'd2);
    check("B_valido", 32'(valido), 32'd1);
    check("B_fine_count", 32'(fine_n), 32'd1);
`ifdef LETTURA_PRIMO_INDICE_EN
    check("B_trovato", 32'(trovato), 32'd1);
    check("B_indice", 32'(indice_primo), 32'h42);
`endif

    // C: no word matches
    for (int i = 0; i < 512; i++) mem[i] = '0;
    pattern  = 32'h1;
    maschera = 32'hFFFFFFFF;
    start_scan();
    wait_fine("C");
    check("C_conteggio", 32'(conteggio), 32'd0);
    check("C_valido", 32'(valido), 32'd1);
    check("C_fine_count", 32'(fine_n), 32'd1);
`ifdef LETTURA_PRIMO_INDICE_EN
    check("C_trovato", 32'(trovato), 32'd0);
    check("C_indice", 32'(indice_primo), 32'd0);
`endif

    // D: abort while comparing entry 100, then rescan
    pattern  = 32'h0;
    maschera = 32'h0;
    start_scan();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (addr == 9'd100) break;
    end
    check("D_reached_100", 32'(addr), 32'd100);
    repeat (2) @(negedge clk);
    state = ST_IDLE;
    #1;
    check("D_abort_avanza", 32'(avanza), 32'd0);
    check("D_abort_fine", 32'(fine_lettura), 32'd0);
    repeat (5) @(negedge clk);
    check("D_fine_count", 32'(fine_n), 32'd0);
    check("D_avanza_count", 32'(av_n), 32'd100);
    check("D_valido", 32'(valido), 32'd0);
    check("D_occupato", 32'(occupato), 32'd0);
    start_scan();
    wait_fine("D_rescan");
    check("D_rescan_conteggio", 32'(conteggio), 32'd512);
    check("D_rescan_valido", 32'(valido), 32'd1);

    // E: back-to-back scan with mask 0
    @(negedge clk);
    state = ST_IDLE;
    repeat (3) @(negedge clk);
    check("E_idle_keep_valido", 32'(valido), 32'd1);
    check("E_idle_keep_conteggio", 32'(conteggio), 32'd512);
    start_scan();
    @(negedge clk);
    check("E_entry_valido", 32'(valido), 32'd0);
    check("E_entry_conteggio", 32'(conteggio), 32'd0);
    check("E_entry_occupato", 32'(occupato), 32'd1);
    wait_fine("E");
    check("E_conteggio", 32'(conteggio), 32'd512);
    check("E_avanza_count", 32'(av_n), 32'd511);

    // F: asynchronous reset between clock edges mid-scan
    start_scan();
    repeat (50) @(negedge clk);
    check("F_occupato_before", 32'(occupato), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    state = ST_IDLE;
    #1;
    check("F_async_conteggio", 32'(conteggio), 32'd0);
    check("F_async_occupato", 32'(occupato), 32'd0);
    check("F_async_valido", 32'(valido), 32'd0);
    check("F_async_avanza", 32'(avanza), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    begin
      int av_before;
      av_before = av_n;
      repeat (30) @(negedge clk);
      check("F_quiet_avanza", 32'(av_n - av_before), 32'd0);
      check("F_quiet_occupato", 32'(occupato), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
